// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA sprite controller.
package vga_pkg;

  localparam int unsigned RGB_W   = 12;  // {R[3:0], G[3:0], B[3:0]}
  localparam int unsigned CNT_W   = 11;  // raster counters and coordinates
  localparam int unsigned COORD_W = 12;  // hit-test width, one bit of headroom

  typedef logic [RGB_W-1:0] rgb_t;

  // 1024x768 @ 65 MHz pixel clock
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BACK   = 160;
  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FRONT  = 24;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BACK   = 29;
  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FRONT  = 3;

  // 640x480 @ 25 MHz pixel clock
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;

  // Raster side-band carried down the pixel pipeline next to the colour path.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             fs;
    logic [CNT_W-1:0] hx;
    logic [CNT_W-1:0] vy;
  } raster_t;

  // Total period of one axis (line length or frame height).
  function automatic int unsigned calc_tot(input int unsigned sync, input int unsigned back,
                                           input int unsigned active, input int unsigned front);
    return sync + back + active + front;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational decode of sync, active area and coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = XGA_H_SYNC,
  parameter int unsigned H_BACK   = XGA_H_BACK,
  parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = XGA_H_FRONT,
  parameter int unsigned V_SYNC   = XGA_V_SYNC,
  parameter int unsigned V_BACK   = XGA_V_BACK,
  parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = XGA_V_FRONT,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             hs_c,
  output logic             vs_c,
  output logic             act_c,
  output logic [CNT_W-1:0] hx_c,
  output logic [CNT_W-1:0] vy_c,
  output logic             wrap_c,
  output logic             origin_c
);

  localparam int unsigned H_TOT = calc_tot(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int unsigned V_TOT = calc_tot(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYN   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic             SYNC_ACT = 1'(SYNC_POL);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Next counter values: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode of the current counter position.
  always_comb begin
    hs_c     = (h_cnt_q < H_SYN) ? SYNC_ACT : ~SYNC_ACT;
    vs_c     = (v_cnt_q < V_SYN) ? SYNC_ACT : ~SYNC_ACT;
    act_c    = (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
               (v_cnt_q >= V_START) && (v_cnt_q < V_END);
    hx_c     = h_cnt_q - H_START;
    vy_c     = v_cnt_q - V_START;
    wrap_c   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    origin_c = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/vga_sprite_ctrl.sv
// VGA timing plus NUM_SPR-layer sprite compositor with external 1-cycle ROMs.
// Build option: define VGA_SPR_COLOR_KEY_EN to make KEY_COLOR sprite pixels transparent.
module vga_sprite_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC    = XGA_H_SYNC,
  parameter int unsigned H_BACK    = XGA_H_BACK,
  parameter int unsigned H_ACTIVE  = XGA_H_ACTIVE,
  parameter int unsigned H_FRONT   = XGA_H_FRONT,
  parameter int unsigned V_SYNC    = XGA_V_SYNC,
  parameter int unsigned V_BACK    = XGA_V_BACK,
  parameter int unsigned V_ACTIVE  = XGA_V_ACTIVE,
  parameter int unsigned V_FRONT   = XGA_V_FRONT,
  parameter int unsigned SYNC_POL  = 0,
  parameter int unsigned NUM_SPR   = 3,
  parameter int unsigned SPR_W     = 128,
  parameter int unsigned SPR_H     = 128,
  parameter int unsigned AW        = 14,
  parameter rgb_t        BG_COLOR  = 12'hFFF,
  parameter rgb_t        KEY_COLOR = 12'hFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SPR*CNT_W-1:0] spr_x,
  input  logic [NUM_SPR*CNT_W-1:0] spr_y,
  input  logic [NUM_SPR-1:0]       spr_en,
  output logic [NUM_SPR*AW-1:0]    rom_addr,
  input  logic [NUM_SPR*RGB_W-1:0] rom_data,
  output logic                     hs,
  output logic                     vs,
  output logic                     de,
  output logic [RGB_W-1:0]         vga_data,
  output logic                     frame_start,
  output logic [CNT_W-1:0]         h_addr,
  output logic [CNT_W-1:0]         v_addr
);

`ifdef VGA_SPR_COLOR_KEY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  localparam logic    SYNC_ACT = 1'(SYNC_POL);
  localparam raster_t RAS_RST  = '{hs: ~SYNC_ACT, vs: ~SYNC_ACT, de: 1'b0, fs: 1'b0,
                                   hx: '0, vy: '0};

  logic             hs0_c, vs0_c, act0_c, wrap_c, origin_c;
  logic [CNT_W-1:0] hx0_c, vy0_c;

  vga_timing_gen #(
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .hs_c     (hs0_c),
    .vs_c     (vs0_c),
    .act_c    (act0_c),
    .hx_c     (hx0_c),
    .vy_c     (vy0_c),
    .wrap_c   (wrap_c),
    .origin_c (origin_c)
  );

  logic [NUM_SPR*CNT_W-1:0] shx_q, shx_d, shy_q, shy_d;
  logic [NUM_SPR-1:0]       shen_q, shen_d;
  logic [NUM_SPR-1:0]       hit0_c, hit1_q, hit1_d, hit2_q, hit2_d;
  logic [NUM_SPR*AW-1:0]    addr0_c, rom_addr_q, rom_addr_d;
  raster_t                  ras1_q, ras1_d, ras2_q, ras2_d;
  logic [COORD_W-1:0]       hx0_w, vy0_w;
  rgb_t                     pix_c;

  assign hx0_w = COORD_W'(hx0_c);
  assign vy0_w = COORD_W'(vy0_c);

  // Per-sprite hit test and ROM address, derived directly from the coordinates.
  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
    logic [COORD_W-1:0] x_c, y_c, dx_c, dy_c;
    logic               hit_c;

    // 12-bit compares keep sprites near coordinate 2047 from wrapping onto the left edge.
    always_comb begin
      x_c   = COORD_W'(shx_q[gi*CNT_W +: CNT_W]);
      y_c   = COORD_W'(shy_q[gi*CNT_W +: CNT_W]);
      dx_c  = hx0_w - x_c;
      dy_c  = vy0_w - y_c;
      hit_c = shen_q[gi] && act0_c &&
              (hx0_w >= x_c) && (hx0_w < x_c + COORD_W'(SPR_W)) &&
              (vy0_w >= y_c) && (vy0_w < y_c + COORD_W'(SPR_H));
    end

    assign hit0_c[gi]            = hit_c;
    assign addr0_c[gi*AW +: AW] = hit_c ? AW'(32'(dy_c) * SPR_W + 32'(dx_c)) : '0;
  end

  // Shadow positions follow the inputs only at the frame wrap; pipeline stages advance each clock.
  always_comb begin
    shx_d      = shx_q;
    shy_d      = shy_q;
    shen_d     = shen_q;
    if (wrap_c) begin
      shx_d  = spr_x;
      shy_d  = spr_y;
      shen_d = spr_en;
    end
    rom_addr_d = addr0_c;
    hit1_d     = hit0_c;
    hit2_d     = hit1_q;
    ras1_d     = '{hs: hs0_c, vs: vs0_c, de: act0_c, fs: origin_c, hx: hx0_c, vy: vy0_c};
    ras2_d     = ras1_q;
  end

  // Shadow registers and the two pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shx_q      <= '0;
      shy_q      <= '0;
      shen_q     <= '0;
      rom_addr_q <= '0;
      hit1_q     <= '0;
      hit2_q     <= '0;
      ras1_q     <= RAS_RST;
      ras2_q     <= RAS_RST;
    end else begin
      shx_q      <= shx_d;
      shy_q      <= shy_d;
      shen_q     <= shen_d;
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_d;
      hit2_q     <= hit2_d;
      ras1_q     <= ras1_d;
      ras2_q     <= ras2_d;
    end
  end

  // Priority mux: the ROM output register is the pixel register, so the colour is selected
  // from registered ROM data and registered hit flags; the lowest opaque index wins.
  always_comb begin
    pix_c = BG_COLOR;
    for (int j = NUM_SPR - 1; j >= 0; j--) begin
      if (hit2_q[j] && !(KEY_EN && (rom_data[j*RGB_W +: RGB_W] == KEY_COLOR))) begin
        pix_c = rom_data[j*RGB_W +: RGB_W];
      end
    end
    vga_data = ras2_q.de ? pix_c : '0;
  end

  assign rom_addr    = rom_addr_q;
  assign hs          = ras2_q.hs;
  assign vs          = ras2_q.vs;
  assign de          = ras2_q.de;
  assign frame_start = ras2_q.fs;
  assign h_addr      = ras2_q.hx;
  assign v_addr      = ras2_q.vy;

endmodule

// File: doc/vga_sprite_ctrl.md
# vga_sprite_ctrl

Parametrised VGA timing generator and multi-sprite compositor, the successor to the single-sprite display controller in the dinosaur game. It generates HS/VS/DE for any timing set, overlays up to `NUM_SPR` fixed-size sprites fetched from external synchronous ROMs, and produces one 12-bit RGB pixel per clock. Game logic drives sprite positions and enables; this block owns all raster timing, ROM addressing and layer priority.

## Interface

Parameters:
- `H_SYNC` (136): horizontal sync pulse, in pixels.
- `H_BACK` (160): horizontal back porch.
- `H_ACTIVE` (1024): horizontal visible width.
- `H_FRONT` (24): horizontal front porch.
- `V_SYNC` (6), `V_BACK` (29), `V_ACTIVE` (768), `V_FRONT` (3): vertical equivalents, in lines.
- `SYNC_POL` (0): active level of HS/VS. 0 means active-low.
- `NUM_SPR` (3): sprite count, 1..8.
- `SPR_W` (128), `SPR_H` (128): sprite size in pixels.
- `AW` (14): sprite ROM address width; must satisfy 2^AW ≥ SPR_W·SPR_H.
- `BG_COLOR` (12'hFFF): colour where no sprite is opaque.
- `KEY_COLOR` (12'hFFF): transparent colour (used only when `COLOR_KEY_EN` is defined).

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: reset, asynchronous, active-high.
- `spr_x` in NUM_SPR·11: per-sprite left edge, relative to the active origin. Sprite i occupies bits [11i+10:11i].
- `spr_y` in NUM_SPR·11: per-sprite top edge, same packing as `spr_x`.
- `spr_en` in NUM_SPR: per-sprite visibility.
- `rom_addr` out NUM_SPR·AW: per-sprite ROM address.
- `rom_data` in NUM_SPR·12: per-sprite ROM data; the ROM has 1-cycle read latency.
- `hs` out 1: horizontal sync.
- `vs` out 1: vertical sync.
- `de` out 1: display enable.
- `vga_data` out 12: pixel colour as {R[3:0], G[3:0], B[3:0]}.
- `frame_start` out 1: one-cycle pulse at the start of each frame.
- `h_addr` out 11: active-area column of the pixel currently on `vga_data`.
- `v_addr` out 11: active-area row of the pixel currently on `vga_data`.

## Operation

**Counters**
- `h_cnt` counts 0..H_TOT-1, where H_TOT = H_SYNC+H_BACK+H_ACTIVE+H_FRONT. Both counters are 11-bit.
- `v_cnt` counts 0..V_TOT-1 and increments when `h_cnt` wraps.

**Sync and active region**
- Sync is active when `h_cnt` < H_SYNC (HS) or `v_cnt` < V_SYNC (VS).
- The active region is H_SYNC+H_BACK ≤ `h_cnt` < H_SYNC+H_BACK+H_ACTIVE, with the same rule vertically.
- Active coordinates are hx = `h_cnt` − (H_SYNC+H_BACK) and vy = `v_cnt` − (V_SYNC+V_BACK).

**Position latching**
- `spr_x`, `spr_y` and `spr_en` are sampled into shadow registers only on the clock edge where the counters wrap to (0,0).
- Position changes mid-frame never tear the image.
- Reset clears the shadow enables to 0.

**Hit test and addressing, per sprite i**
- Sprite i is hit when: it is enabled, the pixel is active, x_i ≤ hx < x_i+SPR_W, and y_i ≤ vy < y_i+SPR_H.
- The hit comparisons use 12-bit arithmetic, so a sprite near the 2047 limit is not aliased.
- On a hit, `rom_addr`_i = (vy−y_i)·SPR_W + (hx−x_i), computed from the coordinates with no running counter. Otherwise `rom_addr`_i holds 0.
- Sprites extending past the right or bottom edge are clipped. A sprite with x ≥ H_ACTIVE or y ≥ V_ACTIVE is invisible.

**Composition**
- The lowest index has the highest priority.
- `vga_data` is the data of the lowest-index sprite that is hit and opaque. If none qualifies, `vga_data` = BG_COLOR.
- Outside the active region, `vga_data` = 0.

## Timing

**Reset values**
- `hs` = `vs` = !SYNC_POL.
- `de` = 0, `vga_data` = 0, `frame_start` = 0.
- `h_addr` = `v_addr` = 0, and both counters = 0.

**Pipeline**
- Stage 0: counters.
- Stage 1: `rom_addr` is registered and the hit flags are registered.
- Stage 2: `rom_data` is valid, the composite is computed, and outputs are registered.

**Latency and alignment**
- The pixel for counter position (h,v) appears on `vga_data` two cycles after the counters hold (h,v).
- `hs`, `vs`, `de`, `h_addr` and `v_addr` are delayed by the same two cycles, so all outputs stay mutually aligned.
- `frame_start` is asserted in the cycle in which delayed `h`/`v` equal (0,0).

**Reset during operation**
- An asynchronous assert forces all outputs to their reset values immediately.
- After release, the counters restart from (0,0) and the first full frame begins.

## Configuration

- `VGA_SPR_COLOR_KEY_EN` defined: a sprite pixel equal to KEY_COLOR is transparent. Lower-priority sprites, or BG_COLOR, show through.
- `VGA_SPR_COLOR_KEY_EN` undefined: every hit pixel is opaque, and KEY_COLOR is ignored.

## Structure

- Package `vga_pkg` holds:
  - the default timing constants for 1024×768@65 MHz and 640×480@25 MHz;
  - the RGB444 type/width constant;
  - the function computing H_TOT/V_TOT.
- Sub-module `vga_timing_gen` contains the counters, sync generation, active flag, hx/vy and the frame-wrap strobe.
- `vga_sprite_ctrl` instantiates `vga_timing_gen` and adds the shadow registers, the per-sprite hit/address logic (generate loop), the priority mux and the delay line.

## Test plan

1. **Free-run timing:** all spr_en = 0, default parameters.
   - HS period is 1344 clocks, with a low pulse of 136.
   - VS period is 1344·806 clocks, with a low pulse of 6 lines.
   - `de` is high for 1024 clocks per line on 768 lines.
   - `vga_data` = 12'hFFF whenever `de` = 1.
2. **Single sprite:** sprite 0 at (30,300), ROM returning data = address.
   - Pixel (30,300) shows data 0, and pixel (157,427) shows data 16383.
   - Pixels (29,300) and (158,300) show BG_COLOR.
   - Output lags `rom_addr` by exactly 1 cycle.
3. **Overlap priority:** sprites 0 and 1 both cover (100,100).
   - The output shows sprite 0's data.
   - With `COLOR_KEY_EN` and sprite 0 data = 12'hFFF, the output shows sprite 1's data.
4. **Clipping:** sprite at (960,720).
   - Only 64×48 pixels are visible.
   - No hit occurs on columns 0..63 of the next line.
   - A sprite at x = 1100 is never visible.
5. **Tear-free update:** change `spr_y` from 300 to 200 mid-frame at line 400.
   - The current frame still renders at 300.
   - The next frame renders at 200.
   - `frame_start` pulses once per frame.
6. **Reset during a frame:** assert `rst` at line 500.
   - `hs`/`vs` go high (inactive), and `de` and `vga_data` go to 0, asynchronously.
   - After release, the first VS pulse occurs 2 cycles plus 0 lines later.
